// File: rtl/parity_checker_if.sv
// Handshake and status bundle between a parity-checked source and parity_checker.
// master drives the word, parity bit and clear; slave returns ready, checked word and error status.
interface parity_checker_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              din_valid;
  logic              din_ready;
  logic [DATA_W-1:0] din;
  logic              par_in;
  logic              clr;
  logic              dout_valid;
  logic [DATA_W-1:0] dout;
  logic              par_err;
  logic              err_sticky;
  logic              locked;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output din_valid, din, par_in, clr,
    input  din_ready, dout_valid, dout, par_err, err_sticky, locked, err_cnt
  );

  modport slave (
    input  din_valid, din, par_in, clr,
    output din_ready, dout_valid, dout, par_err, err_sticky, locked, err_cnt
  );
endinterface

// File: rtl/parity_checker.sv
// Even-parity receive checker: 1-cycle registered output, ready drops while LOCKED after ERR_THRESH errors in a row.
// Optional saturating total-error counter on err_cnt enabled by macro PARITY_ERR_CNT_EN.
module parity_checker #(
  parameter int DATA_W     = 8,
  parameter int ERR_THRESH = 4,
  parameter int CNT_W      = 16
) (
  input logic             clk,
  input logic             rst,
  parity_checker_if.slave bus
);

  typedef enum logic {RUN = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [7:0] THRESH = 8'(ERR_THRESH);

  state_t     state, state_nxt;
  logic [7:0] consec, consec_nxt;
  logic       sticky_nxt;
  logic       mismatch;
  logic       xfer;

  assign mismatch      = (^bus.din) ^ bus.par_in;
  // clr reopens the input in the same cycle so a word offered with clr is never dropped
  assign bus.din_ready = (state == RUN) || bus.clr;
  assign xfer          = bus.din_valid && bus.din_ready;
  assign bus.locked    = (state == LOCKED);

  always_comb begin
    state_nxt  = state;
    consec_nxt = consec;
    sticky_nxt = bus.err_sticky;
    if (bus.clr) begin
      state_nxt  = RUN;
      consec_nxt = '0;
      sticky_nxt = 1'b0;
    end else if (xfer) begin
      if (mismatch) begin
        sticky_nxt = 1'b1;
        if (consec < THRESH) begin
          consec_nxt = consec + 8'd1;
        end
        if (consec >= THRESH - 8'd1) begin
          state_nxt = LOCKED;
        end
      end else begin
        consec_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= RUN;
      consec         <= '0;
      bus.err_sticky <= 1'b0;
      bus.dout_valid <= 1'b0;
      bus.dout       <= '0;
      bus.par_err    <= 1'b0;
    end else begin
      state          <= state_nxt;
      consec         <= consec_nxt;
      bus.err_sticky <= sticky_nxt;
      bus.dout_valid <= xfer;
      if (xfer) begin
        bus.dout    <= bus.din;
        bus.par_err <= mismatch;
      end
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (bus.clr) begin
      cnt <= '0;
    end else if (xfer && mismatch && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.err_cnt = cnt;
`else
  assign bus.err_cnt = '0;
`endif

endmodule

// File: tb/tb_parity_checker.sv
// Scoreboarded bench for parity_checker: main instance (ERR_THRESH=4) plus ERR_THRESH=8/CNT_W=2 and ERR_THRESH=1 instances.
module tb_parity_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  parity_checker_if #(.DATA_W(8), .CNT_W(16)) bus ();
  parity_checker_if #(.DATA_W(8), .CNT_W(2))  bus2 ();
  parity_checker_if #(.DATA_W(8), .CNT_W(16)) bus3 ();

  parity_checker #(.DATA_W(8), .ERR_THRESH(4), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  parity_checker #(.DATA_W(8), .ERR_THRESH(8), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));
  parity_checker #(.DATA_W(8), .ERR_THRESH(1), .CNT_W(16)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] exp_q[$];
  logic [8:0] sb_e;

  int m_consec;
  int m_cnt;
  bit m_locked;
  bit m_sticky;

  function automatic logic [15:0] cnt_exp();
`ifdef PARITY_ERR_CNT_EN
    return 16'(m_cnt);
`else
    return 16'd0;
`endif
  endfunction

  // scoreboard: every dout_valid pulse must match the oldest accepted word
  always @(negedge clk) begin
    if (bus.dout_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_extra: dout_valid=1 dout=%h, required no output", bus.dout);
      end else begin
        sb_e = exp_q.pop_front();
        if ({bus.par_err, bus.dout} !== sb_e) begin
          n_bad++;
          $display("FAIL sb_word: par_err/dout=%b/%h, required %b/%h",
                   bus.par_err, bus.dout, sb_e[8], sb_e[7:0]);
        end
      end
    end
  end

  task automatic step(input bit v, input logic [7:0] d, input bit p, input bit c);
    bit mism, acc;
    mism = (^d) ^ p;
    acc  = v && (!m_locked || c);
    if (acc) exp_q.push_back({mism, d});
    if (c) begin
      m_sticky = 0; m_consec = 0; m_cnt = 0; m_locked = 0;
    end else if (acc && mism) begin
      m_sticky = 1;
      if (m_consec < 4) m_consec++;
      if (m_consec >= 4) m_locked = 1;
      if (m_cnt < 65535) m_cnt++;
    end else if (acc) begin
      m_consec = 0;
    end
    bus.din_valid = v; bus.din = d; bus.par_in = p; bus.clr = c;
    @(posedge clk); #1;
    bus.din_valid = 0; bus.clr = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    bus.din_valid = 0;  bus.din = 0;  bus.par_in = 0;  bus.clr = 0;
    bus2.din_valid = 0; bus2.din = 0; bus2.par_in = 0; bus2.clr = 0;
    bus3.din_valid = 0; bus3.din = 0; bus3.par_in = 0; bus3.clr = 0;
    m_consec = 0; m_cnt = 0; m_locked = 0; m_sticky = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.dout_valid, bus.dout, bus.par_err} !== 10'h000) begin
      n_bad++;
      $display("FAIL reset_out: dout_valid/dout/par_err=%b/%h/%b, required 0/00/0",
               bus.dout_valid, bus.dout, bus.par_err);
    end
    n_cmp++;
    if ({bus.err_sticky, bus.locked, bus.din_ready, bus.err_cnt} !== {3'b001, 16'h0}) begin
      n_bad++;
      $display("FAIL reset_status: sticky/locked/ready/cnt=%b/%b/%b/%0d, required 0/0/1/0",
               bus.err_sticky, bus.locked, bus.din_ready, bus.err_cnt);
    end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_good_word();
    step(1, 8'hA5, 0, 0);
    n_cmp++;
    if ({bus.dout_valid, bus.par_err, bus.err_sticky} !== 3'b100) begin
      n_bad++;
      $display("FAIL good_word: valid/par_err/sticky=%b%b%b, required 100",
               bus.dout_valid, bus.par_err, bus.err_sticky);
    end
    step(0, 8'h00, 0, 0);
  endtask

  task automatic test_single_err();
    step(1, 8'h01, 0, 0);
    n_cmp++;
    if ({bus.par_err, bus.err_sticky, bus.locked} !== 3'b110) begin
      n_bad++;
      $display("FAIL single_err: par_err/sticky/locked=%b%b%b, required 110",
               bus.par_err, bus.err_sticky, bus.locked);
    end
    n_cmp++;
    if (bus.err_cnt !== cnt_exp()) begin
      n_bad++;
      $display("FAIL single_err_cnt: err_cnt=%0d, required %0d", bus.err_cnt, cnt_exp());
    end
    step(0, 8'h00, 0, 0);
  endtask

  task automatic test_lock();
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 8'h07, 0, 0);
      n_cmp++;
      if ({bus.dout_valid, bus.par_err, bus.locked, bus.din_ready} !== {2'b11, i == 3, i != 3}) begin
        n_bad++;
        $display("FAIL lock_word%0d: valid/par_err/locked/ready=%b%b%b%b, required 11%b%b",
                 i, bus.dout_valid, bus.par_err, bus.locked, bus.din_ready, i == 3, i != 3);
      end
    end
    step(1, 8'h07, 0, 0);
    n_cmp++;
    if ({bus.dout_valid, bus.locked} !== 2'b01) begin
      n_bad++;
      $display("FAIL lock_ignore: dout_valid/locked=%b%b, required 01", bus.dout_valid, bus.locked);
    end
    n_cmp++;
    if (bus.err_cnt !== cnt_exp()) begin
      n_bad++;
      $display("FAIL lock_cnt: err_cnt=%0d, required %0d", bus.err_cnt, cnt_exp());
    end
  endtask

  task automatic test_clr_locked();
    step(1, 8'h07, 0, 1);
    n_cmp++;
    if ({bus.locked, bus.din_ready, bus.err_sticky, bus.dout_valid, bus.par_err} !== 5'b01011) begin
      n_bad++;
      $display("FAIL clr_locked: locked/ready/sticky/valid/par_err=%b%b%b%b%b, required 01011",
               bus.locked, bus.din_ready, bus.err_sticky, bus.dout_valid, bus.par_err);
    end
    n_cmp++;
    if (bus.err_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL clr_cnt: err_cnt=%0d, required 0", bus.err_cnt);
    end
    step(0, 8'h00, 0, 0);
  endtask

  task automatic test_consec_reset();
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 8'h07, 0, 0);
    step(1, 8'hA5, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 8'h07, 0, 0);
    n_cmp++;
    if ({bus.locked, bus.err_sticky} !== 2'b01) begin
      n_bad++;
      $display("FAIL consec_reset: locked/sticky=%b%b, required 01", bus.locked, bus.err_sticky);
    end
    n_cmp++;
    if (bus.err_cnt !== cnt_exp()) begin
      n_bad++;
      $display("FAIL consec_cnt: err_cnt=%0d, required %0d", bus.err_cnt, cnt_exp());
    end
    step(0, 8'h00, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      step(1, d, (i == 5) ? ~(^d) : (^d), 0);
    end
    step(0, 8'h00, 0, 0);
    n_cmp++;
    if ({bus.err_sticky, bus.locked} !== 2'b10) begin
      n_bad++;
      $display("FAIL b2b_status: sticky/locked=%b%b, required 10", bus.err_sticky, bus.locked);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_drain: %0d words outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_thresholds();
    logic [1:0] exp2;
`ifdef PARITY_ERR_CNT_EN
    exp2 = 2'd3;
`else
    exp2 = 2'd0;
`endif
    bus2.din_valid = 1; bus2.din = 8'h07; bus2.par_in = 0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus2.err_cnt, bus2.locked} !== {exp2, 1'b0}) begin
      n_bad++;
      $display("FAIL cnt_sat: err_cnt/locked=%0d/%b, required %0d/0", bus2.err_cnt, bus2.locked, exp2);
    end
    repeat (3) @(posedge clk);
    #1;
    bus2.din_valid = 0;
    n_cmp++;
    if ({bus2.locked, bus2.err_cnt} !== {1'b1, exp2}) begin
      n_bad++;
      $display("FAIL thresh8: locked/err_cnt=%b/%0d, required 1/%0d", bus2.locked, bus2.err_cnt, exp2);
    end
    bus3.din_valid = 1; bus3.din = 8'h01; bus3.par_in = 0;
    @(posedge clk); #1;
    bus3.din_valid = 0;
    n_cmp++;
    if ({bus3.locked, bus3.dout_valid, bus3.par_err, bus3.din_ready} !== 4'b1110) begin
      n_bad++;
      $display("FAIL thresh1: locked/valid/par_err/ready=%b%b%b%b, required 1110",
               bus3.locked, bus3.dout_valid, bus3.par_err, bus3.din_ready);
    end
  endtask

  task automatic test_rst_midstream();
    step(1, 8'h3C, 1, 0);
    rst = 1;
    #1;
    exp_q.delete();
    m_consec = 0; m_cnt = 0; m_locked = 0; m_sticky = 0;
    n_cmp++;
    if ({bus.dout_valid, bus.dout, bus.par_err, bus.err_sticky} !== 11'h000) begin
      n_bad++;
      $display("FAIL rst_mid: valid/dout/par_err/sticky=%b/%h/%b/%b, required 0/00/0/0",
               bus.dout_valid, bus.dout, bus.par_err, bus.err_sticky);
    end
    n_cmp++;
    if ({bus2.locked, bus3.locked, bus.din_ready, bus2.err_cnt} !== {3'b001, 2'd0}) begin
      n_bad++;
      $display("FAIL rst_mid_lock: locked2/locked3/ready/cnt2=%b%b%b/%0d, required 001/0",
               bus2.locked, bus3.locked, bus.din_ready, bus2.err_cnt);
    end
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_good_word();
    test_single_err();
    test_lock();
    test_clr_locked();
    test_consec_reset();
    test_back_to_back();
    test_thresholds();
    test_rst_midstream();
    step(0, 8'h00, 0, 0);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL final_drain: %0d words outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
